// File: rtl/vga_rx_checker.sv
// rtl/vga_rx_checker.sv - VGA receive-side checker: sync timing checks, pixel recovery, per-frame colour sum
module vga_rx_checker #(
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_hs,
  input  logic        vga_vs,
  input  logic [3:0]  vga_red,
  input  logic [3:0]  vga_green,
  input  logic [3:0]  vga_blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_done,
  output logic [31:0] frame_sum,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  err_cnt
);
  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [9:0]    CNT_MAX    = 10'h3ff;
  localparam logic [9:0]    H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]    H_SYNC_END = 10'(H_SYNC);
  localparam logic [9:0]    H_ACT_LO   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0]    H_ACT_HI   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0]    V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]    V_SYNC_END = 10'(V_SYNC);
  localparam logic [9:0]    V_ACT_LO   = 10'(V_SYNC + V_BACK);
  localparam logic [9:0]    V_ACT_HI   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE    = DW'(1);

  logic          hs_r, hs_d, vs_r, vs_smp;
  logic [11:0]   rgb_r;
  logic [DW-1:0] div, div_eff, div_nxt;
  logic [9:0]    h_cnt, h_nxt, v_cnt, v_nxt;
  logic          h_synced, v_synced, frame_clean;
  logic [31:0]   acc;
  logic          hs_fall, hs_rise, tick, frame_start, vs_rise;
  logic          h_err_nxt, v_err_nxt, any_err, pv_nxt;
  logic [8:0]    err_sum;

  always_comb begin
    hs_fall = hs_d & ~hs_r;
    hs_rise = ~hs_d & hs_r;
    // The hs falling-edge cycle is pixel position 0, so the edge also counts as a tick.
    div_eff = hs_fall ? '0 : div;
    tick    = (div_eff == '0);
    div_nxt = (div_eff == DIV_LAST) ? '0 : div_eff + DIV_ONE;

    h_nxt = h_cnt;
    if (hs_fall)
      h_nxt = '0;
    else if (tick && h_cnt != CNT_MAX)
      h_nxt = h_cnt + 10'd1;

    frame_start = hs_fall & vs_smp & ~vs_r;
    vs_rise     = hs_fall & ~vs_smp & vs_r;
    v_nxt = v_cnt;
    if (frame_start)
      v_nxt = '0;
    else if (hs_fall && v_cnt != CNT_MAX)
      v_nxt = v_cnt + 10'd1;

    h_err_nxt = h_synced & ((hs_fall & (h_cnt != H_LAST)) |
                            (hs_rise & (h_nxt != H_SYNC_END)) |
                            (~hs_fall & (h_cnt != CNT_MAX) & (h_nxt == CNT_MAX)));
    v_err_nxt = v_synced & ((frame_start & (v_cnt != V_LAST)) |
                            (vs_rise & (v_nxt != V_SYNC_END)));
    any_err   = h_err_nxt | v_err_nxt;

    pv_nxt  = tick & h_synced & v_synced &
              (h_nxt >= H_ACT_LO) & (h_nxt < H_ACT_HI) &
              (v_cnt >= V_ACT_LO) & (v_cnt < V_ACT_HI);
    err_sum = {1'b0, err_cnt} + {8'd0, h_err_nxt} + {8'd0, v_err_nxt};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_r        <= 1'b0;
      hs_d        <= 1'b0;
      vs_r        <= 1'b0;
      vs_smp      <= 1'b0;
      rgb_r       <= '0;
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      h_synced    <= 1'b0;
      v_synced    <= 1'b0;
      frame_clean <= 1'b0;
      acc         <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      frame_sum   <= '0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      err_cnt     <= '0;
    end else begin
      hs_r  <= vga_hs;
      hs_d  <= hs_r;
      vs_r  <= vga_vs;
      rgb_r <= {vga_red, vga_green, vga_blue};
      div   <= div_nxt;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      if (hs_fall) begin
        h_synced <= 1'b1;
        vs_smp   <= vs_r;
      end
      if (frame_start)
        v_synced <= 1'b1;

      pix_valid <= pv_nxt;
      if (pv_nxt) begin
        pix_x   <= h_nxt - H_ACT_LO;
        pix_y   <= v_cnt - V_ACT_LO;
        pix_rgb <= rgb_r;
      end

      h_err   <= h_err_nxt;
      v_err   <= v_err_nxt;
      err_cnt <= err_sum[8] ? 8'hff : err_sum[7:0];

      // Without a prior frame start the accumulated pixels belong to a partial frame.
      frame_done <= frame_start;
      if (frame_start) begin
        frame_sum   <= v_synced ? acc + (pix_valid ? {20'd0, pix_rgb} : 32'd0) : 32'd0;
        acc         <= '0;
        frame_clean <= 1'b1;
      end else begin
        if (pix_valid)
          acc <= acc + {20'd0, pix_rgb};
        if (any_err)
          frame_clean <= 1'b0;
      end

      if (any_err)
        locked <= 1'b0;
      else if (frame_start)
        locked <= v_synced & frame_clean;
    end
  end
endmodule

// File: tb/tb_vga_rx_checker.sv
// tb/tb_vga_rx_checker.sv - directed bench for vga_rx_checker using a shrunken raster
module tb_vga_rx_checker;
  localparam int CD = 2;
  localparam int HS = 4, HB = 3, HA = 8, HF = 2;
  localparam int VS = 2, VB = 2, VA = 4, VF = 1;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_hs, vga_vs;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_rgb;
  logic        frame_done;
  logic [31:0] frame_sum;
  logic        locked, h_err, v_err;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int          pv_total = 0, herr_total = 0, verr_total = 0, fd_total = 0;
  logic [9:0]  first_x = '0, first_y = '0;
  logic [11:0] first_rgb = '0, last_rgb = '0;
  logic [31:0] last_fs = '0;
  logic        lock_at_fd = 1'b0, lock_at_herr = 1'b1;

  logic        rs_pv, rs_lock;
  logic [9:0]  rs_x;
  logic [11:0] rs_rgb;
  logic [31:0] rs_fs;
  logic [7:0]  rs_err;
  int          rs_pv_total;

  vga_rx_checker #(
    .CLK_DIV(CD), .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_sum(frame_sum), .locked(locked),
    .h_err(h_err), .v_err(v_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) begin
      if (pv_total == 0) begin
        first_x = pix_x; first_y = pix_y; first_rgb = pix_rgb;
      end
      if (pix_x == 10'd7 && pix_y == 10'd3) last_rgb = pix_rgb;
      pv_total++;
    end
    if (h_err) begin herr_total++; lock_at_herr = locked; end
    if (v_err) verr_total++;
    if (frame_done) begin fd_total++; last_fs = frame_sum; lock_at_fd = locked; end
  end

  // pat 0: every active pixel 0xFFF; pat 1: {x[3:0], y[3:0], 4'h5}
  task automatic drive_line(input int line, input int hs_len, input int pat, input int rst_at);
    int px, py, idx;
    logic [11:0] rgb;
    for (int h = 0; h < HT; h++) begin
      for (int c = 0; c < CD; c++) begin
        vga_hs = (h < hs_len) ? 1'b0 : 1'b1;
        vga_vs = (line < VS) ? 1'b0 : 1'b1;
        if (h >= HS+HB && h < HS+HB+HA && line >= VS+VB && line < VS+VB+VA) begin
          px = h - (HS+HB);
          py = line - (VS+VB);
          rgb = (pat == 0) ? 12'hfff : {px[3:0], py[3:0], 4'h5};
        end else begin
          rgb = 12'h000;
        end
        {vga_red, vga_green, vga_blue} = rgb;
        idx = h*CD + c;
        if (rst_at >= 0 && idx == rst_at) begin
          rst_n = 1'b0;
          #1;
          rs_pv = pix_valid; rs_x = pix_x; rs_rgb = pix_rgb; rs_fs = frame_sum;
          rs_lock = locked; rs_err = err_cnt; rs_pv_total = pv_total;
        end else if (rst_at >= 0 && idx == rst_at + 3) begin
          rst_n = 1'b1;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic drive_frame(input int nlines, input int pat, input int bad_line,
                             input int rst_line, input int rst_at);
    for (int l = 0; l < nlines; l++)
      drive_line(l, (l == bad_line) ? HS-1 : HS, pat, (l == rst_line) ? rst_at : -1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vga_hs = 1'b1; vga_vs = 1'b1;
    vga_red = 4'hf; vga_green = 4'hf; vga_blue = 4'hf;
    repeat (3) @(posedge clk); #1;
    n_checks++; if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL reset pix_valid got %0d want 0", pix_valid); end
    n_checks++; if (pix_x !== 10'd0) begin n_fail++; $display("FAIL reset pix_x got %0d want 0", pix_x); end
    n_checks++; if (pix_y !== 10'd0) begin n_fail++; $display("FAIL reset pix_y got %0d want 0", pix_y); end
    n_checks++; if (pix_rgb !== 12'd0) begin n_fail++; $display("FAIL reset pix_rgb got %h want 0", pix_rgb); end
    n_checks++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done got %0d want 0", frame_done); end
    n_checks++; if (frame_sum !== 32'd0) begin n_fail++; $display("FAIL reset frame_sum got %0d want 0", frame_sum); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset locked got %0d want 0", locked); end
    n_checks++; if (h_err !== 1'b0) begin n_fail++; $display("FAIL reset h_err got %0d want 0", h_err); end
    n_checks++; if (v_err !== 1'b0) begin n_fail++; $display("FAIL reset v_err got %0d want 0", v_err); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset err_cnt got %0d want 0", err_cnt); end
    rst_n = 1'b1;
    repeat (5) @(posedge clk); #1;
    n_checks++; if (pv_total !== 0) begin n_fail++; $display("FAIL idle pix_valid count got %0d want 0", pv_total); end
  endtask

  task automatic test_gradient();
    int pv0;
    drive_frame(VT, 1, -1, -1, -1);
    pv0 = pv_total;
    drive_frame(VT, 1, -1, -1, -1);
    n_checks++; if (fd_total !== 1) begin n_fail++; $display("FAIL grad first frame_done count got %0d want 1", fd_total); end
    n_checks++; if (last_fs !== 32'd0) begin n_fail++; $display("FAIL grad first frame_sum got %0d want 0", last_fs); end
    n_checks++; if (pv_total - pv0 !== 32) begin n_fail++; $display("FAIL grad strobes got %0d want 32", pv_total - pv0); end
    n_checks++; if (first_x !== 10'd0 || first_y !== 10'd0) begin n_fail++; $display("FAIL grad first xy got %0d,%0d want 0,0", first_x, first_y); end
    n_checks++; if (first_rgb !== 12'h005) begin n_fail++; $display("FAIL grad first rgb got %h want 005", first_rgb); end
    n_checks++; if (last_rgb !== 12'h735) begin n_fail++; $display("FAIL grad last rgb got %h want 735", last_rgb); end
    pv0 = pv_total;
    drive_frame(VT, 1, -1, -1, -1);
    n_checks++; if (last_fs !== 32'd29600) begin n_fail++; $display("FAIL grad frame_sum got %0d want 29600", last_fs); end
    n_checks++; if (lock_at_fd !== 1'b1) begin n_fail++; $display("FAIL grad locked got %0d want 1", lock_at_fd); end
    n_checks++; if (pv_total - pv0 !== 32) begin n_fail++; $display("FAIL grad strobes2 got %0d want 32", pv_total - pv0); end
    n_checks++; if (herr_total + verr_total !== 0) begin n_fail++; $display("FAIL grad errors got %0d want 0", herr_total + verr_total); end
  endtask

  task automatic test_clean_frames();
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (last_fs !== 32'd29600) begin n_fail++; $display("FAIL clean prev sum got %0d want 29600", last_fs); end
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (last_fs !== 32'd131040) begin n_fail++; $display("FAIL clean frame_sum got %0d want 131040", last_fs); end
    n_checks++; if (lock_at_fd !== 1'b1) begin n_fail++; $display("FAIL clean locked got %0d want 1", lock_at_fd); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clean err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_short_hsync();
    int h0;
    h0 = herr_total;
    drive_frame(VT, 0, 5, -1, -1);
    n_checks++; if (herr_total - h0 !== 1) begin n_fail++; $display("FAIL short h_err count got %0d want 1", herr_total - h0); end
    n_checks++; if (lock_at_herr !== 1'b0) begin n_fail++; $display("FAIL short locked at h_err got %0d want 0", lock_at_herr); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL short err_cnt got %0d want 1", err_cnt); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL short locked got %0d want 0", locked); end
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (lock_at_fd !== 1'b0) begin n_fail++; $display("FAIL short relock early got %0d want 0", lock_at_fd); end
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (lock_at_fd !== 1'b1) begin n_fail++; $display("FAIL short relock got %0d want 1", lock_at_fd); end
    n_checks++; if (herr_total - h0 !== 1) begin n_fail++; $display("FAIL short later h_err got %0d want 1", herr_total - h0); end
  endtask

  task automatic test_long_frame();
    int v0, h0;
    v0 = verr_total; h0 = herr_total;
    drive_frame(VT + 1, 1, -1, -1, -1);
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (verr_total - v0 !== 1) begin n_fail++; $display("FAIL long v_err count got %0d want 1", verr_total - v0); end
    n_checks++; if (herr_total - h0 !== 0) begin n_fail++; $display("FAIL long h_err count got %0d want 0", herr_total - h0); end
    n_checks++; if (lock_at_fd !== 1'b0) begin n_fail++; $display("FAIL long locked got %0d want 0", lock_at_fd); end
    n_checks++; if (last_fs !== 32'd29600) begin n_fail++; $display("FAIL long frame_sum got %0d want 29600", last_fs); end
    n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL long err_cnt got %0d want 2", err_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    int fd0, e0, pv0;
    fd0 = fd_total; e0 = herr_total + verr_total;
    drive_frame(VT, 0, -1, 6, 2);
    n_checks++; if (rs_pv !== 1'b0) begin n_fail++; $display("FAIL rstmid pix_valid got %0d want 0", rs_pv); end
    n_checks++; if (rs_x !== 10'd0) begin n_fail++; $display("FAIL rstmid pix_x got %0d want 0", rs_x); end
    n_checks++; if (rs_rgb !== 12'd0) begin n_fail++; $display("FAIL rstmid pix_rgb got %h want 0", rs_rgb); end
    n_checks++; if (rs_fs !== 32'd0) begin n_fail++; $display("FAIL rstmid frame_sum got %0d want 0", rs_fs); end
    n_checks++; if (rs_lock !== 1'b0) begin n_fail++; $display("FAIL rstmid locked got %0d want 0", rs_lock); end
    n_checks++; if (rs_err !== 8'd0) begin n_fail++; $display("FAIL rstmid err_cnt got %0d want 0", rs_err); end
    n_checks++; if (pv_total !== rs_pv_total) begin n_fail++; $display("FAIL rstmid strobes after reset got %0d want 0", pv_total - rs_pv_total); end
    n_checks++; if (fd_total - fd0 !== 1) begin n_fail++; $display("FAIL rstmid frame_done count got %0d want 1", fd_total - fd0); end
    pv0 = pv_total;
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (fd_total - fd0 !== 2) begin n_fail++; $display("FAIL rstmid resync frame_done got %0d want 2", fd_total - fd0); end
    n_checks++; if (last_fs !== 32'd0) begin n_fail++; $display("FAIL rstmid resync sum got %0d want 0", last_fs); end
    n_checks++; if (lock_at_fd !== 1'b0) begin n_fail++; $display("FAIL rstmid resync locked got %0d want 0", lock_at_fd); end
    n_checks++; if (pv_total - pv0 !== 32) begin n_fail++; $display("FAIL rstmid strobes got %0d want 32", pv_total - pv0); end
    drive_frame(VT, 0, -1, -1, -1);
    n_checks++; if (lock_at_fd !== 1'b1) begin n_fail++; $display("FAIL rstmid relock got %0d want 1", lock_at_fd); end
    n_checks++; if (last_fs !== 32'd131040) begin n_fail++; $display("FAIL rstmid frame_sum got %0d want 131040", last_fs); end
    n_checks++; if (herr_total + verr_total !== e0) begin n_fail++; $display("FAIL rstmid errors got %0d want 0", herr_total + verr_total - e0); end
    n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstmid err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_stuck_hsync();
    int h0, pv0;
    h0 = herr_total; pv0 = pv_total;
    vga_hs = 1'b1; vga_vs = 1'b1;
    vga_red = 4'hf; vga_green = 4'hf; vga_blue = 4'hf;
    repeat (1100 * CD) @(posedge clk);
    #1;
    n_checks++; if (herr_total - h0 !== 1) begin n_fail++; $display("FAIL stuck h_err count got %0d want 1", herr_total - h0); end
    n_checks++; if (pv_total - pv0 !== 0) begin n_fail++; $display("FAIL stuck strobes got %0d want 0", pv_total - pv0); end
    n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL stuck err_cnt got %0d want 1", err_cnt); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL stuck locked got %0d want 0", locked); end
  endtask

  initial begin
    test_reset();
    test_gradient();
    test_clean_frames();
    test_short_hsync();
    test_long_frame();
    test_reset_mid_frame();
    test_stuck_hsync();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
